// File: rtl/sr_jk_ff_bank.sv
// sr_jk_ff_bank: WIDTH independent flip-flops sharing one clock and a run-time
// mode select (SR, JK, D, T). SR forbidden inputs hold state, raise a one-cycle
// illegal pulse and bump a saturating counter. qn is a true registered
// complement, and chg flags which bits changed on the last edge.
module sr_jk_ff_bank #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic [WIDTH-1:0] chg,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef enum logic [1:0] {
      MODE_SR = 2'b00,
      MODE_JK = 2'b01,
      MODE_D  = 2'b10,
      MODE_T  = 2'b11
   } mode_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_next;
   logic             fire;

   // Per-bit next-state function for the currently selected mode.
   always_comb begin
      q_next = q;
      for (int i = 0; i < WIDTH; i++) begin
         case (mode_t'(mode))
            MODE_SR: begin
               case ({a[i], b[i]})
                  2'b01:   q_next[i] = 1'b0;
                  2'b10:   q_next[i] = 1'b1;
                  // 2'b11 is forbidden: hold, flagged separately
                  default: q_next[i] = q[i];
               endcase
            end
            MODE_JK: begin
               case ({a[i], b[i]})
                  2'b01:   q_next[i] = 1'b0;
                  2'b10:   q_next[i] = 1'b1;
                  2'b11:   q_next[i] = ~q[i];
                  default: q_next[i] = q[i];
               endcase
            end
            MODE_D:  q_next[i] = a[i];
            default: q_next[i] = q[i] ^ a[i];
         endcase
      end
   end

   // Forbidden SR input on any bit; several bits in one cycle count once.
   always_comb begin
      fire = en & (mode == MODE_SR) & (|(a & b));
   end

   // Flip-flop state, complement and change strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         q   <= '0;
         qn  <= '1;
         chg <= '0;
      end else if (en) begin
         q   <= q_next;
         qn  <= ~q_next;
         chg <= q_next ^ q;
      end else begin
         chg <= '0;
      end
   end

   // Illegal pulse and saturating counter; a clear wins over a same-cycle fire.
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal     <= 1'b0;
         illegal_cnt <= '0;
      end else begin
         illegal <= fire;
         if (cnt_clr) begin
            illegal_cnt <= '0;
         end else if (fire && (illegal_cnt != CNT_MAX)) begin
            illegal_cnt <= illegal_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_sr_jk_ff_bank.sv
// Testbench for sr_jk_ff_bank (WIDTH=4, CNT_W=2): directed scenarios followed by
// randomized traffic, every output compared to a behavioural model each cycle.
module tb_sr_jk_ff_bank;

   localparam int WIDTH   = 4;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int MASK    = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cnt_clr = 1'b0;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qn;
   logic [WIDTH-1:0] chg;
   logic             illegal;
   logic [CNT_W-1:0] illegal_cnt;

   int n_chk = 0;
   int n_err = 0;

   // behavioural model state
   int m_q   = 0;
   int m_chg = 0;
   int m_ill = 0;
   int m_cnt = 0;

   sr_jk_ff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .a           (a),
      .b           (b),
      .cnt_clr     (cnt_clr),
      .q           (q),
      .qn          (qn),
      .chg         (chg),
      .illegal     (illegal),
      .illegal_cnt (illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model written from the per-bit rules, one bit at a time with integers.
   task automatic model_update(input int r, input int e, input int md, input int xa,
                               input int xb, input int c);
      int nq;
      int any_forbidden;
      if (r != 0) begin
         m_q = 0; m_chg = 0; m_ill = 0; m_cnt = 0;
         return;
      end
      any_forbidden = 0;
      nq = 0;
      for (int i = 0; i < WIDTH; i++) begin
         int x, y, qc, n;
         x  = (xa >> i) & 1;
         y  = (xb >> i) & 1;
         qc = (m_q >> i) & 1;
         n  = qc;
         if (md == 0) begin
            if (x == 1 && y == 1) any_forbidden = 1;
            else if (x == 1) n = 1;
            else if (y == 1) n = 0;
         end else if (md == 1) begin
            if (x == 1 && y == 1) n = 1 - qc;
            else if (x == 1) n = 1;
            else if (y == 1) n = 0;
         end else if (md == 2) begin
            n = x;
         end else begin
            n = (x == 1) ? 1 - qc : qc;
         end
         nq = nq + (n << i);
      end
      if (e != 0) begin
         m_chg = nq ^ m_q;
         m_q   = nq;
      end else begin
         m_chg = 0;
      end
      m_ill = (e != 0 && md == 0 && any_forbidden == 1) ? 1 : 0;
      if (c != 0) m_cnt = 0;
      else if (m_ill == 1 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
   endtask

   task automatic step(input logic r, input logic e, input logic [1:0] md,
                       input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic c);
      @(negedge clk);
      rst = r; en = e; mode = md; a = xa; b = xb; cnt_clr = c;
      @(posedge clk);
      model_update(int'(r), int'(e), int'(md), int'(xa), int'(xb), int'(c));
      #1;
      chk("q",   32'(q),           32'(m_q));
      chk("qn",  32'(qn),          32'((~m_q) & MASK));
      chk("chg", 32'(chg),         32'(m_chg));
      chk("ill", 32'(illegal),     32'(m_ill));
      chk("cnt", 32'(illegal_cnt), 32'(m_cnt));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // 1. reset with random inputs
      for (int i = 0; i < 2; i++)
         step(1'b1, 1'b1, 2'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      chk("rst_q",   32'(q), 32'h0);
      chk("rst_qn",  32'(qn), 32'hF);
      chk("rst_chg", 32'(chg), 32'h0);
      chk("rst_ill", 32'(illegal), 32'h0);
      chk("rst_cnt", 32'(illegal_cnt), 32'h0);

      // 2. SR mode
      step(1'b0, 1'b1, 2'b00, 4'b0011, 4'b0000, 1'b0);
      chk("sr1_q", 32'(q), 32'h3);
      chk("sr1_chg", 32'(chg), 32'h3);
      step(1'b0, 1'b1, 2'b00, 4'b0001, 4'b0110, 1'b0);
      chk("sr2_q", 32'(q), 32'h1);
      chk("sr2_chg", 32'(chg), 32'h2);
      step(1'b0, 1'b1, 2'b00, 4'b1001, 4'b1000, 1'b0);
      chk("sr3_q", 32'(q), 32'h1);
      chk("sr3_ill", 32'(illegal), 32'h1);
      chk("sr3_cnt", 32'(illegal_cnt), 32'h1);
      chk("sr3_chg", 32'(chg), 32'h0);

      // 3. JK then T, starting from 0101
      step(1'b0, 1'b1, 2'b10, 4'b0101, 4'b0000, 1'b0);
      chk("d_q", 32'(q), 32'h5);
      step(1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0);
      chk("jk_q", 32'(q), 32'hA);
      chk("jk_chg", 32'(chg), 32'hF);
      step(1'b0, 1'b1, 2'b11, 4'b0011, 4'b0000, 1'b0);
      chk("t1_q", 32'(q), 32'h9);
      chk("t1_qn", 32'(qn), 32'h6);
      step(1'b0, 1'b1, 2'b11, 4'b0011, 4'b0000, 1'b0);
      chk("t2_q", 32'(q), 32'hA);
      chk("t2_qn", 32'(qn), 32'h5);

      // 4. D mode with enable
      step(1'b0, 1'b1, 2'b10, 4'b1100, 4'b0000, 1'b0);
      chk("d1_q", 32'(q), 32'hC);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 2'b10, 4'b0011, 4'b0000, 1'b0);
         chk("dhold_q", 32'(q), 32'hC);
         chk("dhold_chg", 32'(chg), 32'h0);
      end
      step(1'b0, 1'b1, 2'b10, 4'b0011, 4'b0000, 1'b0);
      chk("d2_q", 32'(q), 32'h3);
      chk("d2_chg", 32'(chg), 32'hF);

      // 5. counter saturation and priority
      step(1'b0, 1'b1, 2'b10, 4'b0011, 4'b0000, 1'b1);
      chk("clr_cnt", 32'(illegal_cnt), 32'h0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 2'b00, 4'b1111, 4'b1111, 1'b0);
         chk("sat_cnt", 32'(illegal_cnt), 32'((i < 3) ? i + 1 : 3));
         chk("sat_ill", 32'(illegal), 32'h1);
      end
      step(1'b0, 1'b1, 2'b00, 4'b1111, 4'b1111, 1'b1);
      chk("clrfire_cnt", 32'(illegal_cnt), 32'h0);
      chk("clrfire_ill", 32'(illegal), 32'h1);
      step(1'b0, 1'b0, 2'b00, 4'b1111, 4'b1111, 1'b0);
      chk("dis_ill", 32'(illegal), 32'h0);
      chk("dis_cnt", 32'(illegal_cnt), 32'h0);

      // 6. reset in the middle of a T-mode toggle sequence
      step(1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);
      step(1'b0, 1'b1, 2'b11, 4'b1111, 4'b0000, 1'b0);
      chk("tr1_q", 32'(q), 32'hF);
      step(1'b0, 1'b1, 2'b11, 4'b1111, 4'b0000, 1'b0);
      chk("tr2_q", 32'(q), 32'h0);
      step(1'b1, 1'b1, 2'b11, 4'b1111, 4'b0000, 1'b0);
      chk("trr_q", 32'(q), 32'h0);
      chk("trr_qn", 32'(qn), 32'hF);
      chk("trr_chg", 32'(chg), 32'h0);
      step(1'b0, 1'b1, 2'b11, 4'b1111, 4'b0000, 1'b0);
      chk("tr4_q", 32'(q), 32'hF);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic             r, e, c;
         logic [1:0]       md;
         logic [WIDTH-1:0] xa, xb;
         r  = ($urandom_range(0, 31) == 0);
         e  = ($urandom_range(0, 3) != 0);
         c  = ($urandom_range(0, 7) == 0);
         md = 2'($urandom);
         xa = 4'($urandom);
         xb = ($urandom_range(0, 2) == 0) ? 4'($urandom) & ~xa : 4'($urandom);
         step(r, e, md, xa, xb, c);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/sr_jk_ff_bank.md
# sr_jk_ff_bank

Parametrised bank of WIDTH independent edge-triggered flip-flops sharing one clock and one run-time mode select. The same bank behaves as SR, JK, D or T flip-flops. It supersedes the single-bit SR flip-flop: it defines an explicit response to the SR forbidden input (hold plus flag, never high-Z), adds a true registered complement output and per-bit change strobes, and keeps a saturating forbidden-input counter. It sits between lab stimulus logic (switches and pulse generators) and display or status logic.

## Interface

- WIDTH, 8: number of flip-flops in the bank, 1..32.
- CNT_W, 8: width of the forbidden-input counter, 2..16.

- clk  in  1  rising-edge clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset; sampled on posedge clk.
- en  in  1  update enable; 0 holds all flip-flop state.
- mode  in  2  00 = SR, 01 = JK, 10 = D, 11 = T; sampled every cycle.
- a  in  WIDTH  per-bit primary input: S, J, D or T depending on mode.
- b  in  WIDTH  per-bit secondary input: R in SR mode, K in JK mode; ignored in D and T modes.
- cnt_clr  in  1  synchronous clear of illegal_cnt.
- q  out  WIDTH  flip-flop state.
- qn  out  WIDTH  registered complement of q; always equals ~q.
- chg  out  WIDTH  per-bit strobe: bit i is 1 for one cycle after q[i] changed.
- illegal  out  1  one-cycle pulse: the last enabled SR-mode update saw S=R=1 on at least one bit.
- illegal_cnt  out  CNT_W  saturating count of cycles with a forbidden SR input.

## Operation

- The next-state function is per bit, with qc = current q[i], x = a[i], y = b[i]:
  - SR: xy=00 hold; 01 reset to 0; 10 set to 1; 11 forbidden, so hold qc.
  - JK: 00 hold; 01 reset to 0; 10 set to 1; 11 toggle to ~qc.
  - D: next = x.
  - T: x=1 gives ~qc; x=0 gives hold.
- When en=1, all bits update together. chg = q_next ^ q.
- When en=0, q and qn hold, chg = 0, illegal = 0, and the counter is untouched unless cnt_clr=1.
- Forbidden-input detect: fire = en & (mode==00) & |(a & b).
  - illegal <= fire.
  - A cycle with several forbidden bits counts once.
- Counter priority:
  - rst clears it.
  - Otherwise cnt_clr clears it, even when fire=1 in the same cycle.
  - Otherwise fire increments it, saturating at 2^CNT_W-1 with no wrap.
- A mode change takes effect in the same cycle it is presented. No state is lost: q carries over as the initial state of the new mode.
- X or Z is never driven on any output.

## Timing

- All outputs are registered and change only on posedge clk. Input-to-q latency is 1 cycle.
- Reset values: q = 0, qn = all ones, chg = 0, illegal = 0, illegal_cnt = 0.
- rst=1 overrides en, mode, a, b and cnt_clr. The first update happens on the edge after rst is deasserted.
- rst asserted mid-operation, for example during a T-mode toggle sequence, forces the reset values on that edge. Nothing is buffered.
- chg and illegal are single-cycle pulses. They repeat on consecutive cycles if their condition persists.
- The counter value reflects the cycle that fired on the same edge that raises illegal.

## Test plan

WIDTH=4 and CNT_W=2 unless stated.

1. Reset: hold rst=1 for 2 cycles with random a, b, mode and en=1 -> q=0000, qn=1111, chg=0000, illegal=0, illegal_cnt=0.
2. SR mode, en=1:
   - a=0011, b=0000 -> q=0011, chg=0011.
   - Then a=0001, b=0110 -> q=0001, chg=0010.
   - Then a=1001, b=1000 -> q=0001, illegal=1, illegal_cnt=1, chg=0000.
3. JK and T mode, starting from q=0101:
   - JK with a=1111, b=1111 -> q=1010, chg=1111.
   - Then T with a=0011 on two cycles -> q=1001, then q=1010. qn=~q every cycle.
4. D mode with enable: a=1100, en=1 -> q=1100. Then a=0011, en=0 for 3 cycles -> q stays 1100 and chg=0000. Then en=1 -> q=0011, chg=1111.
5. Counter saturation and priority:
   - SR forbidden input on 5 consecutive cycles -> illegal_cnt goes 1, 2, 3, 3, 3, and illegal stays 1 throughout.
   - Then cnt_clr=1 together with a forbidden input -> illegal_cnt=0 and illegal=1.
   - Same input with en=0 -> illegal=0 and the count does not change.
6. Reset mid-sequence: T mode with a=1111, toggling from 0000, with rst=1 asserted on the 3rd edge -> q=0000, qn=1111, chg=0000 after that edge. The next edge with rst=0 gives q=1111.
